// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier result path.
// Holds status bit indices and the fp_result_t result bundle.
package fp_mult_pkg;

    localparam int STATUS_W = 8;

    localparam int ST_ZERO      = 0;
    localparam int ST_INF       = 1;
    localparam int ST_NAN       = 2;
    localparam int ST_TINY      = 3;
    localparam int ST_HUGE      = 4;
    localparam int ST_INEXACT   = 5;
    localparam int ST_HUGE_INT  = 6;
    localparam int ST_IEEE_COMP = 7;

    typedef struct packed {
        logic [31:0]         z;
        logic [STATUS_W-1:0] status;
    } fp_result_t;

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous FIFO of fp_result_t with wrapping ADDR_W+1 bit pointers.
// Ports: clk, rst, push, pop, wdata, rdata, full, empty, level.
module fp_res_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  fp_result_t        wdata,
    output fp_result_t        rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    fp_result_t        mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[ADDR_W-1:0]];

    assign do_pop  = pop & ~empty;
    // A full FIFO accepts a write only when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/fp_mult_result_buffer.sv
// Result buffer after the FP multiplier: FIFO, sticky flags, drop flag.
// Ports: clk, rst, in_valid/in_z/in_status, out_valid/out_ready/out_z/
// out_status, sticky_status, overflow, sticky_clr, level.
// Macro FP_RES_CNT_EN adds a 16-bit saturating push counter res_count.
module fp_mult_result_buffer
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [31:0]         in_z,
    input  logic [STATUS_W-1:0] in_status,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_z,
    output logic [STATUS_W-1:0] out_status,
    output logic [STATUS_W-1:0] sticky_status,
    output logic                overflow,
    input  logic                sticky_clr,
`ifdef FP_RES_CNT_EN
    output logic [ADDR_W:0]     level,
    output logic [15:0]         res_count
`else
    output logic [ADDR_W:0]     level
`endif
);

    fp_result_t wdata;
    fp_result_t rdata;
    logic       full;
    logic       empty;
    logic       pop;
    logic       push;
    logic       drop;

    assign wdata.z      = in_z;
    assign wdata.status = in_status;

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    // The multiplier cannot stall, so a result arriving at a full,
    // non-draining FIFO is lost.
    assign drop = in_valid & full & ~pop;

    fp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid  = ~empty;
    assign out_z      = rdata.z;
    assign out_status = rdata.status;

    // Clear acts first so a same-cycle accepted status survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_status <= '0;
            overflow      <= 1'b0;
        end else begin
            sticky_status <= (sticky_clr ? '0 : sticky_status) |
                             (push ? in_status : '0);
            overflow      <= (sticky_clr ? 1'b0 : overflow) | drop;
        end
    end

`ifdef FP_RES_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (sticky_clr) begin
            res_count <= {15'd0, push};
        end else if (push && res_count != 16'hFFFF) begin
            res_count <= res_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Self-checking bench for fp_mult_result_buffer against a queue model.
// Define FP_RES_CNT_EN to also exercise the res_count port.
module tb_fp_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_z = '0;
    logic [7:0]  in_status = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [7:0]  sticky_status;
    logic        overflow;
    logic        sticky_clr = 1'b0;
    logic [AW:0] level;
`ifdef FP_RES_CNT_EN
    logic [15:0] res_count;
`endif

    fp_mult_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_z          (in_z),
        .in_status     (in_status),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_z         (out_z),
        .out_status    (out_status),
        .sticky_status (sticky_status),
        .overflow      (overflow),
        .sticky_clr    (sticky_clr),
`ifdef FP_RES_CNT_EN
        .level         (level),
        .res_count     (res_count)
`else
        .level         (level)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a queue of {z,status} plus flag state.
    logic [39:0] q[$];
    logic [7:0]  m_sticky = '0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    task automatic model_reset();
        q.delete();
        m_sticky = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Drive one cycle of inputs, advance model and DUT by one edge.
    task automatic tick(input logic v, input logic [31:0] z,
                        input logic [7:0] s, input logic r,
                        input logic c);
        bit p_pop, p_push, p_drop;
        in_valid = v; in_z = z; in_status = s;
        out_ready = r; sticky_clr = c;
        p_pop  = (q.size() > 0) && r;
        p_push = v && ((q.size() < DEPTH) || p_pop);
        p_drop = v && !p_push;
        @(posedge clk);
        if (p_pop) void'(q.pop_front());
        if (p_push) q.push_back({z, s});
        m_sticky = (c ? 8'h00 : m_sticky) | (p_push ? s : 8'h00);
        m_ovf = (c ? 1'b0 : m_ovf) | p_drop;
        if (c) m_cnt = p_push ? 1 : 0;
        else if (p_push && m_cnt < 65535) m_cnt++;
        #1;
        in_valid = 0; out_ready = 0; sticky_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        checks++;
        if (sticky_status !== 8'h00) begin
            errors++;
            $display("FAIL reset_sticky got %h want 00", sticky_status);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", overflow);
        end
`ifdef FP_RES_CNT_EN
        checks++;
        if (res_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", res_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        tick(1, 32'h3F800000, 8'h00, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'h3F800000) begin
            errors++;
            $display("FAIL single_out got v=%b z=%h want v=1 z=3f800000",
                     out_valid, out_z);
        end
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL single_level got %0d want 1", level);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got lvl=%0d v=%b want 0 0",
                     level, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) tick(1, i, 8'h00, 0, 0);
        tick(1, 5, 8'h00, 0, 0);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_ovf got lvl=%0d ovf=%b want 4 1",
                     level, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_z !== 32'(i)) begin
                errors++;
                $display("FAIL fill_drain got v=%b z=%0d want 1 %0d",
                         out_valid, out_z, i);
            end
            tick(0, 0, 0, 1, 0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty got v=%b want 0", out_valid);
        end
        tick(0, 0, 0, 0, 1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) tick(1, i, 8'h00, 0, 0);
        tick(1, 5, 8'h00, 1, 0);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpp got lvl=%0d ovf=%b want 4 0",
                     level, overflow);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_z !== 32'(i)) begin
                errors++;
                $display("FAIL fullpp_drain got v=%b z=%0d want 1 %0d",
                         out_valid, out_z, i);
            end
            tick(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_sticky();
        tick(0, 0, 0, 0, 1);
        tick(1, 32'h10, 8'h01, 0, 0);
        tick(1, 32'h20, 8'h20, 0, 0);
        checks++;
        if (sticky_status !== 8'h21) begin
            errors++;
            $display("FAIL sticky_acc got %h want 21", sticky_status);
        end
        tick(1, 32'h30, 8'h04, 0, 1);
        checks++;
        if (sticky_status !== 8'h04 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr got %h ovf=%b want 04 0",
                     sticky_status, overflow);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1, 32'hA0 + i, 8'h02, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || sticky_status !== 8'h00)
        begin
            errors++;
            $display("FAIL async_rst got v=%b lvl=%0d st=%h want 0 0 00",
                     out_valid, level, sticky_status);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick(1'($urandom_range(0, 2) != 0), $urandom,
                 8'(1 << $urandom_range(0, 7)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
            checks++;
            if (out_valid !== (q.size() > 0) || level !== (AW + 1)'(q.size()))
            begin
                errors++;
                $display("FAIL rand_lvl got v=%b lvl=%0d want lvl=%0d",
                         out_valid, level, q.size());
            end
            checks++;
            if (sticky_status !== m_sticky || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_flags got %h %b want %h %b",
                         sticky_status, overflow, m_sticky, m_ovf);
            end
            if (q.size() > 0) begin
                checks++;
                if ({out_z, out_status} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_head got %h want %h",
                             {out_z, out_status}, q[0]);
                end
            end
`ifdef FP_RES_CNT_EN
            checks++;
            if (res_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_cnt got %0d want %0d", res_count, m_cnt);
            end
`endif
        end
    endtask

`ifdef FP_RES_CNT_EN
    task automatic test_counter();
        tick(0, 0, 0, 1, 1);
        while (q.size() > 0) tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, i, 0, 1, 0);
        checks++;
        if (res_count !== 16'd3) begin
            errors++;
            $display("FAIL cnt3 got %0d want 3", res_count);
        end
        tick(1, 9, 0, 1, 1);
        checks++;
        if (res_count !== 16'd1) begin
            errors++;
            $display("FAIL cnt_clr got %0d want 1", res_count);
        end
        for (int i = 0; i < 65536; i++) tick(1, i, 0, 1, 0);
        checks++;
        if (res_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat got %h want ffff", res_count);
        end
        tick(1, 1, 0, 1, 0);
        checks++;
        if (res_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_hold got %h want ffff", res_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_sticky();
        test_async_reset();
        test_random();
`ifdef FP_RES_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
